// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its write-side controller.
// Holds opcode/operand/address types, the instruction bundle and FSM states.
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef enum logic {CLEAR, RUN} ctrl_state_t;

  localparam int ADDR_W = $bits(address_t);
  localparam int CNT_W  = ADDR_W + 1;

  localparam instruction_t INSTR_NOP = '{
    opc:  ZERO,
    op_a: '0,
    op_b: '0
  };

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with one-hot grant.
// Priority flips to the other requester only after a granted transfer.
import instr_register_pkg::*;

module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       en,
  output logic [1:0] grant
);

  logic pri1;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req0 && (!req1 || !pri1))
        grant = 2'b01;
      else if (req1)
        grant = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pri1 <= 1'b0;
    else if (grant[0])
      pri1 <= 1'b1;
    else if (grant[1])
      pri1 <= 1'b0;
  end

endmodule

// File: rtl/instr_reg_ctrl.sv
// Write/read-pointer controller for a 32-entry instruction register.
// Optional INSTR_CTRL_CLEAR_EN adds a CLEAR sweep after reset and flush.
import instr_register_pkg::*;

module instr_reg_ctrl #(
  parameter int NUM_ENTRIES = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  opcode_t          req0_opcode,
  input  opcode_t          req1_opcode,
  input  operand_t         req0_operand_a,
  input  operand_t         req0_operand_b,
  input  operand_t         req1_operand_a,
  input  operand_t         req1_operand_b,
  input  logic             rd_pop,
  input  logic             flush,
  output logic             load_en,
  output address_t         write_pointer,
  output opcode_t          opcode,
  output operand_t         operand_a,
  output operand_t         operand_b,
  output address_t         read_pointer,
  output logic             rd_valid,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             busy
);

  logic             run;
  logic             clr;
  logic             arb_en;
  logic             accept;
  logic             pop_ok;
  logic [1:0]       grant;
  address_t         wp_q;
  address_t         rp_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ld_q;
  instruction_t     in_sel;
  instruction_t     data_q;

`ifdef INSTR_CTRL_CLEAR_EN
  localparam address_t LAST = address_t'(NUM_ENTRIES - 1);

  ctrl_state_t state_q;

  assign clr  = state_q == CLEAR;
  assign run  = state_q == RUN;
  assign busy = clr;

  // CLEAR writes are combinational so slot 0 lands in the first cycle
  assign load_en   = ld_q | (clr & reset_n);
  assign opcode    = clr ? ZERO : data_q.opc;
  assign operand_a = clr ? '0 : data_q.op_a;
  assign operand_b = clr ? '0 : data_q.op_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_q <= CLEAR;
    else if (flush)
      state_q <= CLEAR;
    else if (clr && wp_q == LAST)
      state_q <= RUN;
  end
`else
  assign clr  = 1'b0;
  assign run  = 1'b1;
  assign busy = 1'b0;

  assign load_en   = ld_q;
  assign opcode    = data_q.opc;
  assign operand_a = data_q.op_a;
  assign operand_b = data_q.op_b;
`endif

  assign full     = cnt_q == CNT_W'(NUM_ENTRIES);
  assign count    = cnt_q;
  assign rd_valid = run & (cnt_q != '0);

  assign write_pointer = wp_q;
  assign read_pointer  = rp_q;

  assign arb_en = reset_n & run & ~full & ~flush;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req0    (req0_valid),
    .req1    (req1_valid),
    .en      (arb_en),
    .grant   (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;
  assign pop_ok     = rd_pop & rd_valid & ~flush;

  always_comb begin
    in_sel = '{
      opc:  req0_opcode,
      op_a: req0_operand_a,
      op_b: req0_operand_b
    };
    if (grant[1])
      in_sel = '{
        opc:  req1_opcode,
        op_a: req1_operand_a,
        op_b: req1_operand_b
      };
  end

  // wp_q advances after each shown write, so a load shows its own slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      ld_q   <= 1'b0;
      data_q <= INSTR_NOP;
    end else if (flush) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ld_q  <= 1'b0;
    end else begin
      ld_q <= accept;
      if (accept)
        data_q <= in_sel;
      else if (clr)
        data_q <= INSTR_NOP;
      if (clr || ld_q)
        wp_q <= wp_q + 1'b1;
      if (pop_ok)
        rp_q <= rp_q + 1'b1;
      if (accept && !pop_ok)
        cnt_q <= cnt_q + 1'b1;
      else if (pop_ok && !accept)
        cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_reg_ctrl.sv
// Scoreboard bench for instr_reg_ctrl: stimulus queues expected writes,
// a negedge monitor pops and compares each load_en strobe in RUN.
import instr_register_pkg::*;

module tb_instr_reg_ctrl;

`ifdef INSTR_CTRL_CLEAR_EN
  localparam logic CLR_EN = 1'b1;
`else
  localparam logic CLR_EN = 1'b0;
`endif

  typedef struct {
    address_t wp;
    opcode_t  opc;
    operand_t a;
    operand_t b;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  opcode_t          req0_opcode, req1_opcode;
  operand_t         req0_operand_a, req0_operand_b;
  operand_t         req1_operand_a, req1_operand_b;
  logic             rd_pop, flush;
  logic             load_en;
  address_t         write_pointer, read_pointer;
  opcode_t          opcode;
  operand_t         operand_a, operand_b;
  logic             rd_valid, full, busy;
  logic [CNT_W-1:0] count;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  instr_reg_ctrl #(.NUM_ENTRIES(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req0_valid     (req0_valid),
    .req1_valid     (req1_valid),
    .req0_ready     (req0_ready),
    .req1_ready     (req1_ready),
    .req0_opcode    (req0_opcode),
    .req1_opcode    (req1_opcode),
    .req0_operand_a (req0_operand_a),
    .req0_operand_b (req0_operand_b),
    .req1_operand_a (req1_operand_a),
    .req1_operand_b (req1_operand_b),
    .rd_pop         (rd_pop),
    .flush          (flush),
    .load_en        (load_en),
    .write_pointer  (write_pointer),
    .opcode         (opcode),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .read_pointer   (read_pointer),
    .rd_valid       (rd_valid),
    .count          (count),
    .full           (full),
    .busy           (busy)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int wp, input opcode_t o,
                      input int a, input int b);
    exp_t e;
    e.wp  = address_t'(wp);
    e.opc = o;
    e.a   = operand_t'(a);
    e.b   = operand_t'(b);
    exp_q.push_back(e);
  endtask

  task automatic drv0(input int i);
    req0_opcode    = ADD;
    req0_operand_a = operand_t'(100 + i);
    req0_operand_b = operand_t'(i);
  endtask

  task automatic drv1(input int i);
    req1_opcode    = SUB;
    req1_operand_a = operand_t'(200 + i);
    req1_operand_b = operand_t'(50 + i);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && !busy && load_en) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_load: wp=%0d opc=%0d expected no load",
                 write_pointer, opcode);
      end else begin
        e = exp_q.pop_front();
        chk("load_wp", write_pointer, e.wp);
        chk("load_opc", opcode, e.opc);
        chk("load_a", operand_a, e.a);
        chk("load_b", operand_b, e.b);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] g0_pat;
    g0_pat = 4'b0101;
    reset_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rd_pop = 1'b0;
    flush = 1'b0;
    drv0(0);
    drv1(0);
    #3;
    chk("rst_load_en", load_en, 0);
    chk("rst_wp", write_pointer, 0);
    chk("rst_rp", read_pointer, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_opcode", opcode, ZERO);
    chk("rst_opa", operand_a, 0);
    chk("rst_opb", operand_b, 0);
    chk("rst_r0", req0_ready, 0);
    chk("rst_r1", req1_ready, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
`ifdef INSTR_CTRL_CLEAR_EN
    for (int i = 0; i < 32; i++) begin
      if (i != 0) begin
        @(negedge clk);
        #1;
      end
      chk("clr_busy", busy, 1);
      chk("clr_load_en", load_en, 1);
      chk("clr_wp", write_pointer, i);
      chk("clr_opc", opcode, ZERO);
      chk("clr_ready", req0_ready, 0);
    end
    @(negedge clk);
    #1;
`endif
    chk("run_busy", busy, 0);
    chk("run_rd_valid", rd_valid, 0);
    chk("run_wp", write_pointer, 0);
    chk("run_load_en", load_en, 0);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      drv0(i);
      drv1(i);
      #1;
      chk("arb_r0", req0_ready, g0_pat[i]);
      chk("arb_r1", req1_ready, !g0_pat[i]);
      if (g0_pat[i])
        push(i, ADD, 100 + i, i);
      else
        push(i, SUB, 200 + i, 50 + i);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("arb_count", count, 4);

    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      req0_valid = 1'b1;
      drv0(i + 10);
      #1;
      chk("fill_ready", req0_ready, 1);
      push(4 + i, ADD, 110 + i, 10 + i);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("fill_count", count, 32);
    chk("fill_full", full, 1);
    @(negedge clk);
    chk("fill_wp_wrap", write_pointer, 0);
    req0_valid = 1'b1;
    rd_pop = 1'b1;
    drv0(40);
    #1;
    chk("full_ready", req0_ready, 0);
    chk("full_rd_valid", rd_valid, 1);
    @(negedge clk);
    rd_pop = 1'b0;
    #1;
    chk("full_pop_count", count, 31);
    chk("full_pop_full", full, 0);
    chk("full_pop_rp", read_pointer, 1);
    chk("refill_ready", req0_ready, 1);
    push(0, ADD, 140, 40);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("refill_count", count, 32);

    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      rd_pop = 1'b1;
    end
    @(negedge clk);
    rd_pop = 1'b0;
    #1;
    chk("drain_count", count, 1);
    chk("drain_rp", read_pointer, 0);
    @(negedge clk);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rd_pop = 1'b1;
    drv0(50);
    drv1(50);
    #1;
    chk("both_r1", req1_ready, 1);
    chk("both_r0", req0_ready, 0);
    push(1, SUB, 250, 100);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rd_pop = 1'b0;
    #1;
    chk("both_count", count, 1);
    chk("both_rp", read_pointer, 1);
    @(negedge clk);
    chk("both_wp", write_pointer, 2);

    rd_pop = 1'b1;
    @(negedge clk);
    #1;
    chk("empty_rd_valid", rd_valid, 0);
    chk("empty_count0", count, 0);
    @(negedge clk);
    rd_pop = 1'b0;
    #1;
    chk("empty_rp", read_pointer, 2);
    chk("empty_count", count, 0);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req0_valid = 1'b1;
      drv0(60 + i);
      #1;
      push(2 + i, ADD, 160 + i, 60 + i);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("pre_flush_count", count, 5);
    @(negedge clk);
    flush = 1'b1;
    req0_valid = 1'b1;
    rd_pop = 1'b1;
    #1;
    chk("flush_ready", req0_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    req0_valid = 1'b0;
    rd_pop = 1'b0;
    #1;
    chk("flush_count", count, 0);
    chk("flush_rp", read_pointer, 0);
    chk("flush_wp", write_pointer, 0);
    chk("flush_busy", busy, CLR_EN);
`ifndef INSTR_CTRL_CLEAR_EN
    chk("flush_load_en", load_en, 0);
`endif
    for (int k = 0; k < 40 && busy; k++)
      @(negedge clk);
    chk("flush_done", busy, 0);
    @(negedge clk);
    req0_valid = 1'b1;
    drv0(70);
    #1;
    chk("post_flush_ready", req0_ready, 1);
    push(0, ADD, 170, 70);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("post_flush_count", count, 1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_reg_ctrl.md
INSTR_REG_CTRL -- requirements
Module: instr_reg_ctrl

Interface
REQ-001 SHALL have parameter: NUM_ENTRIES, 32, instruction register depth; equals 2**$bits(address_t).
REQ-002 SHALL have one clock, clk; reset is asynchronous and active-low, named reset_n.
REQ-003 Ports, in order:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- req0_valid / req1_valid  in  1  requester has an instruction
- req0_ready / req1_ready  out  1  instruction accepted this cycle
- req0_opcode / req1_opcode  in  opcode_t  opcode
- req0_operand_a, req0_operand_b / req1_operand_a, req1_operand_b  in  operand_t  operands
- rd_pop  in  1  consumer takes the entry at read_pointer
- flush  in  1  discard contents and restart
- load_en  out  1  write strobe to the instruction register
- write_pointer  out  address_t  write slot
- opcode  out  opcode_t  write data
- operand_a, operand_b  out  operand_t  write data
- read_pointer  out  address_t  oldest valid slot
- rd_valid  out  1  at least one entry held
- count  out  $bits(address_t)+1  occupancy, 0..NUM_ENTRIES
- full  out  1  count == NUM_ENTRIES
- busy  out  1  in CLEAR state

Function
REQ-004 FSM states SHALL be CLEAR and RUN.
- CLEAR: write_pointer steps 0..NUM_ENTRIES-1, one slot per cycle, with load_en=1, opcode=ZERO, operands=0; then enter RUN with write_pointer=0.
REQ-005 In CLEAR, req0_ready, req1_ready and rd_valid SHALL be 0, and rd_pop SHALL be ignored.
REQ-006 In RUN, a requester SHALL be granted only when its valid is 1 and full is 0; req_ready is combinational, at most one per cycle.
REQ-007 Arbitration SHALL be two-way round-robin.
- Both valid: grant the requester not granted last.
- After reset: req0 has priority.
- The last-grant record updates only on an accepted transfer.
REQ-008 Accepted instruction SHALL appear on opcode/operand_a/operand_b with load_en=1 exactly one cycle later, at the current write_pointer.
- write_pointer then increments, wrapping NUM_ENTRIES-1 -> 0.
REQ-009 load_en SHALL be 0 in every RUN cycle following a non-accept; data outputs hold their last value.
REQ-010 rd_valid SHALL equal (count != 0) in RUN.
- rd_pop with rd_valid=1: read_pointer increments with wrap, visible next cycle.
- rd_pop with rd_valid=0: ignored.
REQ-011 count SHALL update as follows: +1 on accept only, -1 on valid pop only, unchanged on both or neither.
REQ-012 When full, no accept SHALL occur even if rd_pop is asserted in the same cycle; ready may rise the cycle after count drops.
REQ-013 flush in RUN SHALL, on the next edge, zero count, read_pointer and write_pointer.
- Any same-cycle accept or pop is dropped.
- Enters CLEAR if INSTR_CTRL_CLEAR_EN is defined, else stays in RUN.
REQ-014 flush during CLEAR SHALL restart CLEAR from slot 0.

Reset
REQ-015 Assertion of reset_n=0 SHALL immediately force:
- load_en=0, write_pointer=0, read_pointer=0, count=0, full=0, rd_valid=0
- opcode=ZERO, operand_a=0, operand_b=0
- req0_ready=0, req1_ready=0
- arbiter priority to req0
REQ-016 After reset release, the FSM SHALL be in CLEAR (macro defined) or RUN (macro undefined), with busy=1 or 0 respectively.
REQ-017 Reset mid-CLEAR or mid-RUN SHALL abandon all state; no partial write completes.

Configuration
REQ-018 Macro INSTR_CTRL_CLEAR_EN SHALL control the CLEAR sequence.
- Defined: CLEAR is compiled in and runs after reset and flush.
- Undefined: CLEAR logic is absent, busy is tied to 0, and reset/flush go directly to RUN.

Structure
REQ-019 instr_register_pkg SHALL hold opcode_t, operand_t, address_t, instruction_t and the new ctrl_state_t enum {CLEAR, RUN}.
REQ-020 Arbitration SHALL live in sub-module rr_arbiter2: two requests and an enable in, one-hot grant out, with the last-grant flop internal.

Verification
REQ-021 Benches SHALL cover the following directed scenarios:
- Reset, macro defined -> busy=1 for 32 cycles, load_en=1 with write_pointer 0..31 and opcode=ZERO; then busy=0, rd_valid=0.
- Both requesters valid for 4 cycles (RUN, empty) -> grants req0, req1, req0, req1; load_en one cycle after each; write_pointer 0,1,2,3; count=4.
- 32 accepts with no pops -> full=1, count=32, write_pointer wrapped to 0; 33rd request with simultaneous rd_pop -> ready=0, count=31 next cycle.
- count=1, accept and rd_pop in the same cycle -> count stays 1, both pointers advance by 1.
- rd_pop while empty -> read_pointer and count unchanged.
- flush at count=5 -> next cycle count=0, both pointers 0, busy=1 (macro defined) or 0 (undefined).
